// File: rtl/axis_packer.sv
// axis_packer: narrow-to-wide AXI-stream upsizer.
// Packs RATIO consecutive DATA_W-bit beats little-endian into one wide beat
// held in a registered output stage, so the input keeps streaming while a
// wide word waits for the consumer.
// Optional feature macro: AXIS_PACKER_TIMEOUT_EN flushes a partial word
// after TIMEOUT idle cycles, with m_tkeep marking the filled lanes.
module axis_packer #(
  parameter int DATA_W  = 32,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    s_aclk,
  input  logic                    s_areset,
  input  logic                    s_tvalid,
  input  logic [DATA_W-1:0]       s_tdata,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [RATIO*DATA_W-1:0] m_tdata,
  output logic [RATIO-1:0]        m_tkeep,
  input  logic                    m_tready
);

  localparam int CNT_W  = $clog2(RATIO);
  localparam int WIDE_W = RATIO * DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [WIDE_W-1:0] acc_r, acc_nxt_s, acc_ins_s;
  logic              tvalid_r, tvalid_nxt_s;
  logic [WIDE_W-1:0] tdata_r, tdata_nxt_s;
  logic [RATIO-1:0]  tkeep_r, tkeep_nxt_s;
  logic              in_acc_s, out_acc_s, cnt_last_s;

  assign cnt_last_s = (cnt_r == CNT_LAST);
  // A completing beat may only enter when the output register can take it.
  assign s_tready   = !cnt_last_s || !tvalid_r || m_tready;
  assign in_acc_s   = s_tvalid && s_tready;
  assign out_acc_s  = tvalid_r && m_tready;
  assign m_tvalid   = tvalid_r;
  assign m_tdata    = tdata_r;
  assign m_tkeep    = tkeep_r;

  // Accumulator image with the incoming beat dropped into lane cnt_r
  always_comb begin
    acc_ins_s = acc_r;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        acc_ins_s[i*DATA_W +: DATA_W] = s_tdata;
      end else begin
        acc_ins_s[i*DATA_W +: DATA_W] = acc_r[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef AXIS_PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_r, idle_nxt_s;
  logic              flush_s;
  logic [RATIO-1:0]  flush_keep_s;

  // Idle tracking, flush decision and keep mask for a partial word
  always_comb begin
    flush_keep_s = {RATIO{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      flush_keep_s[i] = (CNT_W'(i) < cnt_r);
    end
    // An accepted beat always wins over a flush in the same cycle.
    flush_s = !in_acc_s && (cnt_r != {CNT_W{1'b0}}) && (idle_r == IDLE_MAX) &&
              (!tvalid_r || m_tready);
    if (in_acc_s || flush_s) begin
      idle_nxt_s = {IDLE_W{1'b0}};
    end else if ((cnt_r != {CNT_W{1'b0}}) && (idle_r != IDLE_MAX)) begin
      idle_nxt_s = idle_r + IDLE_W'(1'b1);
    end else begin
      // Saturates at IDLE_MAX while the output register is busy.
      idle_nxt_s = idle_r;
    end
  end

  // Idle counter register
  always_ff @(posedge s_aclk) begin
    if (!s_areset) begin
      idle_r <= {IDLE_W{1'b0}};
    end else begin
      idle_r <= idle_nxt_s;
    end
  end
`endif

  // Next lane counter, accumulator and output register contents
  always_comb begin
    cnt_nxt_s    = cnt_r;
    acc_nxt_s    = acc_r;
    tdata_nxt_s  = tdata_r;
    tkeep_nxt_s  = tkeep_r;
    if (out_acc_s) begin
      tvalid_nxt_s = 1'b0;
    end else begin
      tvalid_nxt_s = tvalid_r;
    end
    if (in_acc_s) begin
      // Counter wraps naturally because RATIO is a power of two.
      cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      if (cnt_last_s) begin
        tdata_nxt_s  = acc_ins_s;
        tkeep_nxt_s  = {RATIO{1'b1}};
        tvalid_nxt_s = 1'b1;
        acc_nxt_s    = {WIDE_W{1'b0}};
      end else begin
        acc_nxt_s = acc_ins_s;
      end
`ifdef AXIS_PACKER_TIMEOUT_EN
    end else if (flush_s) begin
      // Unfilled lanes are already zero because the accumulator is cleared.
      tdata_nxt_s  = acc_r;
      tkeep_nxt_s  = flush_keep_s;
      tvalid_nxt_s = 1'b1;
      acc_nxt_s    = {WIDE_W{1'b0}};
      cnt_nxt_s    = {CNT_W{1'b0}};
`endif
    end else begin
      cnt_nxt_s = cnt_r;
      acc_nxt_s = acc_r;
    end
  end

  // State and output registers; reset discards partial and held words
  always_ff @(posedge s_aclk) begin
    if (!s_areset) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {WIDE_W{1'b0}};
      tvalid_r <= 1'b0;
      tdata_r  <= {WIDE_W{1'b0}};
      tkeep_r  <= {RATIO{1'b0}};
    end else begin
      cnt_r    <= cnt_nxt_s;
      acc_r    <= acc_nxt_s;
      tvalid_r <= tvalid_nxt_s;
      tdata_r  <= tdata_nxt_s;
      tkeep_r  <= tkeep_nxt_s;
    end
  end

endmodule

// File: tb/tb_axis_packer.sv
// Directed self-checking bench for axis_packer (DATA_W=32, RATIO=4, TIMEOUT=16).
// With AXIS_PACKER_TIMEOUT_EN defined the timeout flush is checked; otherwise
// the bench checks that a partial word is held indefinitely.
module tb_axis_packer;

  logic         s_aclk;
  logic         s_areset;
  logic         s_tvalid;
  logic [31:0]  s_tdata;
  logic         s_tready;
  logic         m_tvalid;
  logic [127:0] m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [131:0] wq[$];  // {keep, data} of every wide beat accepted downstream

  axis_packer #(.DATA_W(32), .RATIO(4), .TIMEOUT(16)) dut (
    .s_aclk  (s_aclk),
    .s_areset(s_areset),
    .s_tvalid(s_tvalid),
    .s_tdata (s_tdata),
    .s_tready(s_tready),
    .m_tvalid(m_tvalid),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tready(m_tready)
  );

  initial s_aclk = 1'b0;
  always #5 s_aclk = ~s_aclk;

  // Record every wide handshake
  always @(posedge s_aclk) begin
    if (s_areset && m_tvalid && m_tready) wq.push_back({m_tkeep, m_tdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge s_aclk);
    #1;
  endtask

  // Offer one narrow beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic [31:0] d);
    int w;
    w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    #1;
    while (!s_tready && w < 50) begin
      step();
      w++;
    end
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_beat: s_tready=%b required 1 for beat %h", s_tready, d);
    end
    @(posedge s_aclk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
  endtask

  task automatic test_reset();
    s_areset = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
    m_tready = 1'b0;
    repeat (3) step();
    s_areset = 1'b1;
    step();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    n_checks++;
    if (m_tkeep !== 4'h0) begin n_fail++; $display("FAIL reset_tkeep: got %h required 0", m_tkeep); end
    n_checks++;
    if (m_tdata !== 128'h0) begin n_fail++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    n_checks++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b required 1", s_tready); end
  endtask

  task automatic test_basic_pack();
    m_tready = 1'b1;
    wq.delete();
    send_beat(32'h11);
    send_beat(32'h22);
    send_beat(32'h33);
    send_beat(32'h44);
    n_checks++;
    if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_tvalid: got %b required 1", m_tvalid); end
    n_checks++;
    if (m_tdata !== 128'h00000044_00000033_00000022_00000011) begin
      n_fail++; $display("FAIL basic_tdata: got %h required 00000044000000330000002200000011", m_tdata);
    end
    n_checks++;
    if (m_tkeep !== 4'hF) begin n_fail++; $display("FAIL basic_tkeep: got %h required f", m_tkeep); end
    step();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b required 0", m_tvalid); end
    n_checks++;
    if (wq.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d required 1", wq.size()); end
  endtask

  task automatic test_streaming();
    int stalls;
    logic [127:0] exp_w;
    stalls = 0;
    m_tready = 1'b1;
    wq.delete();
    for (int i = 0; i < 64; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'hA000_0000 + 32'(i);
      #1;
      if (s_tready !== 1'b1) stalls++;
      @(posedge s_aclk);
      #1;
    end
    s_tvalid = 1'b0;
    repeat (2) step();
    n_checks++;
    if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d required 0", stalls); end
    n_checks++;
    if (wq.size() != 16) begin n_fail++; $display("FAIL stream_count: got %0d required 16", wq.size()); end
    for (int j = 0; j < 16 && j < wq.size(); j++) begin
      exp_w = {32'hA000_0000 + 32'(4*j+3), 32'hA000_0000 + 32'(4*j+2),
               32'hA000_0000 + 32'(4*j+1), 32'hA000_0000 + 32'(4*j)};
      n_checks++;
      if (wq[j] !== {4'hF, exp_w}) begin
        n_fail++; $display("FAIL stream_word%0d: got %h required %h", j, wq[j], {4'hF, exp_w});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] w1, w2;
    int bad;
    w1 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    w2 = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    bad = 0;
    m_tready = 1'b0;
    wq.delete();
    send_beat(32'hA1);
    send_beat(32'hA2);
    send_beat(32'hA3);
    send_beat(32'hA4);
    send_beat(32'hB1);
    send_beat(32'hB2);
    send_beat(32'hB3);
    s_tvalid = 1'b1;
    s_tdata  = 32'hB4;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== w1 || m_tkeep !== 4'hF) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad held cycles required 0", bad); end
    m_tready = 1'b1;
    #1;
    n_checks++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got s_tready=%b required 1", s_tready); end
    @(posedge s_aclk);
    #1;
    s_tvalid = 1'b0;
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== w2) begin
      n_fail++; $display("FAIL bp_second: got v=%b %h required v=1 %h", m_tvalid, m_tdata, w2);
    end
    step();
    n_checks++;
    if (wq.size() != 2) begin
      n_fail++; $display("FAIL bp_count: got %0d required 2", wq.size());
    end else begin
      n_checks++;
      if (wq[0] !== {4'hF, w1} || wq[1] !== {4'hF, w2}) begin
        n_fail++; $display("FAIL bp_order: got %h %h required %h %h", wq[0], wq[1], {4'hF, w1}, {4'hF, w2});
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    m_tready = 1'b1;
    send_beat(32'hC1);
    send_beat(32'hC2);
    s_areset = 1'b0;
    step();
    s_areset = 1'b1;
    wq.delete();
    send_beat(32'hD1);
    send_beat(32'hD2);
    send_beat(32'hD3);
    send_beat(32'hD4);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== {32'hD4, 32'hD3, 32'hD2, 32'hD1}) begin
      n_fail++; $display("FAIL midreset_word: got v=%b %h required v=1 000000d4000000d3000000d2000000d1", m_tvalid, m_tdata);
    end
    step();
    n_checks++;
    if (wq.size() != 1) begin n_fail++; $display("FAIL midreset_count: got %0d required 1", wq.size()); end
  endtask

  task automatic test_timeout();
    int first_k;
    logic [127:0] seen_d;
    logic [3:0] seen_k;
    first_k = 0;
    seen_d = 128'h0;
    seen_k = 4'h0;
    m_tready = 1'b1;
    send_beat(32'hE1);
    send_beat(32'hE2);
    send_beat(32'hE3);
`ifdef AXIS_PACKER_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      step();
      if (m_tvalid === 1'b1 && first_k == 0) begin
        first_k = k;
        seen_d  = m_tdata;
        seen_k  = m_tkeep;
      end
    end
    n_checks++;
    if (first_k != 16) begin n_fail++; $display("FAIL timeout_delay: got %0d required 16", first_k); end
    n_checks++;
    if (seen_k !== 4'h7) begin n_fail++; $display("FAIL timeout_keep: got %h required 7", seen_k); end
    n_checks++;
    if (seen_d !== {32'h0, 32'hE3, 32'hE2, 32'hE1}) begin
      n_fail++; $display("FAIL timeout_data: got %h required 00000000000000e3000000e2000000e1", seen_d);
    end
    send_beat(32'hF1);
    send_beat(32'hF2);
    send_beat(32'hF3);
    repeat (15) step();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b required 0", m_tvalid); end
`else
    repeat (40) step();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL hold_partial: got %b required 0", m_tvalid); end
    send_beat(32'hE4);
    n_checks++;
    if (m_tdata !== {32'hE4, 32'hE3, 32'hE2, 32'hE1} || m_tkeep !== 4'hF) begin
      n_fail++; $display("FAIL hold_complete: got %h keep %h required 000000e4000000e3000000e2000000e1 keep f", m_tdata, m_tkeep);
    end
    step();
    send_beat(32'hF1);
    send_beat(32'hF2);
    send_beat(32'hF3);
    repeat (15) step();
`endif
    send_beat(32'hF4);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tkeep !== 4'hF || m_tdata !== {32'hF4, 32'hF3, 32'hF2, 32'hF1}) begin
      n_fail++; $display("FAIL late_beat: got v=%b keep %h %h required v=1 keep f 000000f4000000f3000000f2000000f1", m_tvalid, m_tkeep, m_tdata);
    end
    repeat (20) step();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL no_extra_flush: got %b required 0", m_tvalid); end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_streaming();
    test_backpressure();
    test_reset_mid_fill();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
